// File: rtl/vp_key_event_fifo.sv
// Key event FIFO between the PS/2 / gamepad decoders and vp_keymap.
// Events are presented one at a time with an enforced idle gap and a presentation timeout.
module vp_key_event_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 1048576
) (
    input  logic                       clk_i,
    input  logic                       res_n_i,
    input  logic                       flush_i,
    input  logic                       evt_valid_i,
    input  logic [7:0]                 evt_ascii_i,
    input  logic                       evt_released_i,
    output logic                       evt_full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       rx_data_ready_o,
    output logic [7:0]                 rx_ascii_o,
    output logic                       rx_released_o,
    input  logic                       rx_read_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_nxt;
    logic          full_q;
    state_t        state;
    logic [TW-1:0] timer;
    logic [7:0]    gap;
    logic          push_req, push, pop;

    // Pops only come from IDLE with a non-empty FIFO, so an entry is never read in the cycle it is written.
    always_comb begin
        push_req  = evt_valid_i && (evt_ascii_i != 8'h00);
        pop       = (state == IDLE) && (count != '0);
        push      = push_req && ((count != (AW+1)'(DEPTH)) || pop);
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= {evt_released_i, evt_ascii_i};
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state           <= IDLE;
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
            full_q          <= 1'b0;
            timer           <= '0;
            gap             <= '0;
            ovf_o           <= 1'b0;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= '0;
            rx_released_o   <= 1'b0;
        end else if (flush_i) begin
            state           <= IDLE;
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
            full_q          <= 1'b0;
            timer           <= '0;
            gap             <= '0;
            ovf_o           <= 1'b0;
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= '0;
            rx_released_o   <= 1'b0;
        end else begin
            count  <= count_nxt;
            full_q <= (count_nxt == (AW+1)'(DEPTH));
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push_req && !push) begin
                ovf_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        {rx_released_o, rx_ascii_o} <= mem[rptr];
                        rx_data_ready_o <= 1'b1;
                        timer           <= '0;
                        state           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (rx_read_i) begin
                        rx_data_ready_o <= 1'b0;
                        gap             <= '0;
                        state           <= GAP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        // Unacknowledged event is discarded and reported like a drop.
                        rx_data_ready_o <= 1'b0;
                        ovf_o           <= 1'b1;
                        gap             <= '0;
                        state           <= GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (gap == 8'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign level_o    = count;
    assign evt_full_o = full_q;

endmodule

// File: tb/tb_vp_key_event_fifo.sv
// Self-checking bench for vp_key_event_fifo: directed scenarios plus randomized traffic
// against a queue-based reference of stored and presented events.
module tb_vp_key_event_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 64;
    localparam int          LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          flush = 1'b0;
    logic          evt_valid = 1'b0;
    logic [7:0]    evt_ascii = 8'h00;
    logic          evt_rel = 1'b0;
    logic          rx_read = 1'b0;
    logic          evt_full;
    logic [LW-1:0] level;
    logic          ovf;
    logic          rx_ready;
    logic [7:0]    rx_ascii;
    logic          rx_rel;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ack = -1;
    logic [8:0] exp_q[$];

    vp_key_event_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .res_n_i(res_n), .flush_i(flush),
        .evt_valid_i(evt_valid), .evt_ascii_i(evt_ascii), .evt_released_i(evt_rel),
        .evt_full_o(evt_full), .level_o(level), .ovf_o(ovf),
        .rx_data_ready_o(rx_ready), .rx_ascii_o(rx_ascii), .rx_released_o(rx_rel),
        .rx_read_i(rx_read)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic [7:0] a, input logic r);
        evt_valid = 1'b1;
        evt_ascii = a;
        evt_rel   = r;
        tick();
        evt_valid = 1'b0;
        evt_ascii = 8'h00;
        evt_rel   = 1'b0;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        last_ack = -1;
        exp_q.delete();
    endtask

    // Accept n presented events in order, acknowledging each on its first ready cycle.
    task automatic drain(input int n);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!rx_ready && w < 200) begin
                tick();
                w++;
            end
            tests++;
            if (!rx_ready) begin
                fails++;
                $display("FAIL drain_wait: rx_data_ready=0 after %0d cycles, required 1", w);
                return;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
            tests++;
            if ({rx_rel, rx_ascii} !== e) begin
                fails++;
                $display("FAIL drain_data: got %h required %h", {rx_rel, rx_ascii}, e);
            end
            if (last_ack >= 0) begin
                tests++;
                if (cyc - last_ack < int'(GAP) + 2) begin
                    fails++;
                    $display("FAIL drain_gap: %0d cycles from ack, required >= %0d", cyc - last_ack, GAP + 2);
                end
            end
            rx_read = 1'b1;
            last_ack = cyc;
            tick();
            rx_read = 1'b0;
            tests++;
            if (rx_ready !== 1'b0) begin
                fails++;
                $display("FAIL drain_ack_drop: rx_data_ready=%b required 0", rx_ready);
            end
        end
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({rx_ready, rx_ascii, rx_rel, level, evt_full, ovf} !== '0) begin
            fails++;
            $display("FAIL reset_state: ready=%b ascii=%h rel=%b level=%0d full=%b ovf=%b required all 0",
                     rx_ready, rx_ascii, rx_rel, level, evt_full, ovf);
        end
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        push_evt(8'h35, 1'b0);
        tests++;
        if (rx_ready !== 1'b0 || level !== LW'(1)) begin
            fails++;
            $display("FAIL single_n1: ready=%b level=%0d required 0/1", rx_ready, level);
        end
        tick();
        tests++;
        if (rx_ready !== 1'b1 || rx_ascii !== 8'h35 || rx_rel !== 1'b0 || level !== LW'(0)) begin
            fails++;
            $display("FAIL single_n2: ready=%b ascii=%h rel=%b level=%0d required 1/35/0/0",
                     rx_ready, rx_ascii, rx_rel, level);
        end
        rx_read = 1'b1;
        last_ack = cyc;
        tick();
        rx_read = 1'b0;
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_ack: ready=%b required 0", rx_ready);
        end
        repeat (GAP + 1) tick();
    endtask

    task automatic test_burst;
        int peak = 0;
        for (int i = 0; i < 3; i++) begin
            evt_valid = 1'b1;
            evt_ascii = 8'h31 + 8'(i);
            evt_rel   = 1'b0;
            exp_q.push_back({1'b0, 8'h31 + 8'(i)});
            tick();
            if (int'(level) > peak) peak = int'(level);
        end
        evt_valid = 1'b0;
        evt_ascii = 8'h00;
        tests++;
        if (peak != 2) begin
            fails++;
            $display("FAIL burst_peak: level peak %0d required 2", peak);
        end
        drain(3);
    endtask

    task automatic test_overflow;
        do_flush();
        push_evt(8'h40, 1'b0);
        tick();
        tests++;
        if (rx_ready !== 1'b1 || rx_ascii !== 8'h40) begin
            fails++;
            $display("FAIL ovf_present: ready=%b ascii=%h required 1/40", rx_ready, rx_ascii);
        end
        for (int i = 0; i <= int'(DEPTH); i++) begin
            if (i < int'(DEPTH)) exp_q.push_back({1'(i % 2), 8'h41 + 8'(i)});
            push_evt(8'h41 + 8'(i), 1'(i % 2));
        end
        tests++;
        if (level !== LW'(DEPTH) || evt_full !== 1'b1 || ovf !== 1'b1 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_full: level=%0d full=%b ovf=%b ready=%b required %0d/1/1/1",
                     level, evt_full, ovf, rx_ready, DEPTH);
        end
        rx_read = 1'b1;
        last_ack = cyc;
        tick();
        rx_read = 1'b0;
        repeat (GAP) tick();
        // FSM is in IDLE now: this push coincides with the pop at full.
        exp_q.push_back({1'b0, 8'h5a});
        push_evt(8'h5a, 1'b0);
        tests++;
        if (level !== LW'(DEPTH) || evt_full !== 1'b1 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_pushpop: level=%0d full=%b ready=%b required %0d/1/1",
                     level, evt_full, rx_ready, DEPTH);
        end
        drain(int'(DEPTH) + 1);
        tests++;
        if (level !== LW'(0) || evt_full !== 1'b0) begin
            fails++;
            $display("FAIL ovf_empty: level=%0d full=%b required 0/0", level, evt_full);
        end
    endtask

    task automatic test_timeout;
        int w = 0;
        int hi = 0;
        do_flush();
        push_evt(8'h61, 1'b0);
        push_evt(8'h62, 1'b1);
        exp_q.push_back({1'b1, 8'h62});
        while (!rx_ready && w < 20) begin
            tick();
            w++;
        end
        tests++;
        if (rx_ready !== 1'b1 || rx_ascii !== 8'h61) begin
            fails++;
            $display("FAIL tmo_present: ready=%b ascii=%h required 1/61", rx_ready, rx_ascii);
        end
        while (rx_ready && hi < 200) begin
            tick();
            hi++;
        end
        tests++;
        if (hi != int'(TMO)) begin
            fails++;
            $display("FAIL tmo_length: ready held %0d cycles, required %0d", hi, TMO);
        end
        tests++;
        if (ovf !== 1'b1 || level !== LW'(1)) begin
            fails++;
            $display("FAIL tmo_ovf: ovf=%b level=%0d required 1/1", ovf, level);
        end
        last_ack = cyc - 1;
        drain(1);
    endtask

    task automatic test_filter_flush;
        do_flush();
        push_evt(8'h00, 1'b1);
        tick();
        tick();
        tests++;
        if (level !== LW'(0) || rx_ready !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL filter_zero: level=%0d ready=%b ovf=%b required 0/0/0", level, rx_ready, ovf);
        end
        for (int i = 0; i < int'(DEPTH) + 2; i++) push_evt(8'h70 + 8'(i), 1'b0);
        tests++;
        if (rx_ready !== 1'b1 || ovf !== 1'b1 || level !== LW'(DEPTH)) begin
            fails++;
            $display("FAIL flush_pre: ready=%b ovf=%b level=%0d required 1/1/%0d", rx_ready, ovf, level, DEPTH);
        end
        do_flush();
        tests++;
        if (level !== LW'(0) || rx_ready !== 1'b0 || ovf !== 1'b0 || evt_full !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear: level=%0d ready=%b ovf=%b full=%b required 0/0/0/0",
                     level, rx_ready, ovf, evt_full);
        end
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        exp_q.push_back({1'b1, 8'h77});
        push_evt(8'h77, 1'b1);
        drain(1);
    endtask

    task automatic test_async_reset;
        do_flush();
        push_evt(8'h39, 1'b1);
        tick();
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: ready=%b required 1", rx_ready);
        end
        #3 res_n = 1'b0;
        #1;
        tests++;
        if ({rx_ready, rx_ascii, rx_rel, level, evt_full, ovf} !== '0) begin
            fails++;
            $display("FAIL areset_now: ready=%b ascii=%h rel=%b level=%0d full=%b ovf=%b required all 0",
                     rx_ready, rx_ascii, rx_rel, level, evt_full, ovf);
        end
        #2 res_n = 1'b1;
        tick();
        last_ack = -1;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h42});
        push_evt(8'h42, 1'b0);
        tests++;
        if (rx_ready !== 1'b0 || level !== LW'(1)) begin
            fails++;
            $display("FAIL areset_post: ready=%b level=%0d required 0/1", rx_ready, level);
        end
        tick();
        drain(1);
    endtask

    task automatic test_random;
        int cnt = 0;
        int dly = 0;
        logic prev_rdy = 1'b0;
        logic pushed;
        logic [8:0] item;
        logic [8:0] e;
        do_flush();
        for (int k = 0; k < 1500; k++) begin
            evt_valid = 1'b0;
            evt_ascii = 8'h00;
            evt_rel   = 1'b0;
            rx_read   = 1'b0;
            if (cnt < int'(DEPTH) - 1 && $urandom_range(0, 2) == 0) begin
                evt_valid = 1'b1;
                evt_ascii = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                evt_rel   = 1'($urandom_range(0, 1));
            end
            if (rx_ready) begin
                if (dly == 0) begin
                    rx_read = 1'b1;
                    last_ack = cyc;
                end else begin
                    dly--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                rx_read = 1'b1;
            end
            pushed = evt_valid && (evt_ascii != 8'h00);
            item   = {evt_rel, evt_ascii};
            tick();
            if (pushed) begin
                exp_q.push_back(item);
                cnt++;
            end
            if (rx_ready && !prev_rdy) begin
                cnt--;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
                tests++;
                if ({rx_rel, rx_ascii} !== e) begin
                    fails++;
                    $display("FAIL rand_data: got %h required %h", {rx_rel, rx_ascii}, e);
                end
                if (last_ack >= 0) begin
                    tests++;
                    if (cyc - last_ack < int'(GAP) + 2) begin
                        fails++;
                        $display("FAIL rand_gap: %0d cycles from ack, required >= %0d", cyc - last_ack, GAP + 2);
                    end
                end
                dly = $urandom_range(0, 6);
            end
            tests++;
            if (level !== LW'(cnt)) begin
                fails++;
                $display("FAIL rand_level: level=%0d required %0d", level, cnt);
            end
            prev_rdy = rx_ready;
        end
        evt_valid = 1'b0;
        evt_ascii = 8'h00;
        rx_read   = 1'b0;
        drain(exp_q.size());
        tests++;
        if (level !== LW'(0) || ovf !== 1'b0) begin
            fails++;
            $display("FAIL rand_end: level=%0d ovf=%b required 0/0", level, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_timeout();
        test_filter_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
